spi_coeff_loader: RTL and testbench
===================================

Name: spi_coeff_loader

Overview:
- SCLK-domain SPI slave receive path. Accepts coefficient write and commit commands on MOSI.
- Holds a shadow bank and an active bank of ten biquad coefficients, and drives the active bank to the high-pass and low-pass filter stages.
- Flags every commit with a toggle, which the clk_48 consumer synchronises.
- Sits beside the SPI audio-readback slave on the same SCLK/CS/MOSI bus. Never drives MISO.

Parameters:
- COEFF_W, 64: coefficient width in bits, signed.
- CMD_WRITE, 8'h02: opcode for a burst write into the shadow bank.
- CMD_COMMIT, 8'h03: opcode that copies shadow to active.

Ports:
- SCLK  in  1  SPI clock; all state advances on posedge.
- reset_n  in  1  async active-low reset.
- CS  in  1  active-low chip select.
- MOSI  in  1  serial data, MSB first.
- hp_y1_coeff, hp_y2_coeff, hp_x0_coeff, hp_x1_coeff, hp_x2_coeff  out  COEFF_W each  active high-pass coefficients, addresses 0-4.
- lp_y1_coeff, lp_y2_coeff, lp_x0_coeff, lp_x1_coeff, lp_x2_coeff  out  COEFF_W each  active low-pass coefficients, addresses 5-9.
- coeff_update_tgl  out  1  toggles once per commit.
- bad_addr  out  1  sticky; set by a write to address >= 10.
- bad_cmd  out  1  sticky; set by an unknown opcode.

Behaviour:
- Reset:
  - Clock SCLK. Reset reset_n, asynchronous, active-low.
  - Reset clears all shadow and active coefficients to 0.
  - Reset also clears coeff_update_tgl, bad_addr, bad_cmd and the frame state.
- Frame-state clear on CS:
  - While CS=1, frame-state registers (FSM, bit counter, shift register, address pointer) are held cleared asynchronously.
  - Banks and status flags are not affected by CS.
  - A new frame always starts at bit 0, even with no SCLK edge between frames.
- Bit sampling: MOSI is sampled on posedge SCLK while CS=0. The shift register is COEFF_W bits.
- State CMD: collect 8 bits. On the edge that samples bit 7:
  - opcode == CMD_WRITE -> ADDR.
  - opcode == CMD_COMMIT -> on that same edge, active bank <= shadow bank (all ten words atomically) and coeff_update_tgl inverts; then go to IGNORE.
  - Any other opcode -> set bad_cmd, go to IGNORE.
- State ADDR: collect 8 bits into the address pointer, then go to DATA.
- State DATA: collect COEFF_W bits. On the edge that samples the last bit:
  - If ptr < 10: shadow[ptr] <= the assembled word, which includes that last bit.
  - Otherwise no write and bad_addr is set.
  - ptr increments by 1 (8-bit wrap, 255 -> 0); the bit counter returns to 0 and the FSM stays in DATA (burst).
- State IGNORE: consume bits with no effect until CS=1.
- Partial words:
  - CS rising before a word completes discards the partial word. No shadow write, no flag.
  - A commit is never partial: it occurs on the opcode's 8th edge only.
- The active bank changes only on commit. Shadow writes never alter the outputs.
- Latency:
  - A written word reaches shadow on the 80th SCLK edge of the frame for the first word (8 cmd + 8 addr + 64 data).
  - Each further burst word takes 64 more edges.
  - Outputs change on the 8th edge of a COMMIT frame.
- CDC contract: coeff_update_tgl and the active bank change on the same edge. The clk_48 consumer double-flops the toggle and samples the coefficients on a detected edge. The master must not issue a second commit within 4 clk_48 cycles.
- Sticky flags clear only on reset_n.
- reset_n asserted mid-frame clears everything immediately. Subsequent SCLK edges in the same CS-low frame are treated as a new frame from bit 0.

Test Plan:
- Reset, then read all ten outputs -> all 0; coeff_update_tgl=0; bad_addr=0; bad_cmd=0.
- WRITE addr 0x02, data 64'h0000_0001_0000_0000, then CS high -> hp_x0_coeff still 0. COMMIT frame -> hp_x0_coeff=64'h0000_0001_0000_0000 on the 8th edge; tgl=1.
- WRITE addr 0x08 with 3 words A,B,C -> shadow 8=A, 9=B; C dropped; bad_addr=1. After COMMIT: lp_x1=A, lp_x2=B; others unchanged.
- WRITE addr 0x05, 40 data bits, CS high; then COMMIT -> lp_y1_coeff unchanged; bad_addr=0; tgl toggles.
- Opcode 8'hFF followed by 80 bits -> no bank change, bad_cmd=1. A following COMMIT still works.
- Assert reset_n after 70 edges of a WRITE frame to addr 0 -> all banks 0. Release with CS still low: the next 8 bits are decoded as a fresh opcode.

Source files
------------

// File: rtl/spi_coeff_loader.sv
// SPI slave receive path for biquad coefficients. Words are burst-written into a
// shadow bank and copied atomically to the active bank by a commit command.
module spi_coeff_loader #(
    parameter int         COEFF_W    = 64,
    parameter logic [7:0] CMD_WRITE  = 8'h02,
    parameter logic [7:0] CMD_COMMIT = 8'h03
) (
    input  logic                      SCLK,
    input  logic                      reset_n,
    input  logic                      CS,
    input  logic                      MOSI,
    output logic signed [COEFF_W-1:0] hp_y1_coeff,
    output logic signed [COEFF_W-1:0] hp_y2_coeff,
    output logic signed [COEFF_W-1:0] hp_x0_coeff,
    output logic signed [COEFF_W-1:0] hp_x1_coeff,
    output logic signed [COEFF_W-1:0] hp_x2_coeff,
    output logic signed [COEFF_W-1:0] lp_y1_coeff,
    output logic signed [COEFF_W-1:0] lp_y2_coeff,
    output logic signed [COEFF_W-1:0] lp_x0_coeff,
    output logic signed [COEFF_W-1:0] lp_x1_coeff,
    output logic signed [COEFF_W-1:0] lp_x2_coeff,
    output logic                      coeff_update_tgl,
    output logic                      bad_addr,
    output logic                      bad_cmd
);
    localparam int NCOEFF = 10;
    localparam int CW     = $clog2(COEFF_W);

    typedef enum logic [1:0] {ST_CMD, ST_ADDR, ST_DATA, ST_IGNORE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      bitcnt_q, bitcnt_d;
    logic [COEFF_W-2:0] shift_q, shift_d;
    logic [7:0]         ptr_q, ptr_d;
    logic [COEFF_W-1:0] word;
    logic               wr_stb, commit_stb, badcmd_stb;

    logic [COEFF_W-1:0] shadow_q [NCOEFF];
    logic [COEFF_W-1:0] active_q [NCOEFF];
    logic               tgl_q, bad_addr_q, bad_cmd_q;

    // Frame state is held cleared whenever CS is high, so every frame starts at bit 0.
    logic frame_rst_n;
    assign frame_rst_n = reset_n & ~CS;

    // The completed word's last bit is MOSI itself on the sampling edge.
    assign word = {shift_q, MOSI};

    always_ff @(posedge SCLK or negedge frame_rst_n) begin
        if (!frame_rst_n) begin
            state_q  <= ST_CMD;
            bitcnt_q <= '0;
            shift_q  <= '0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            ptr_q    <= ptr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q + CW'(1);
        shift_d    = word[COEFF_W-2:0];
        ptr_d      = ptr_q;
        wr_stb     = 1'b0;
        commit_stb = 1'b0;
        badcmd_stb = 1'b0;
        case (state_q)
            ST_CMD: if (bitcnt_q == CW'(7)) begin
                bitcnt_d = '0;
                if (word[7:0] == CMD_WRITE) begin
                    state_d = ST_ADDR;
                end else if (word[7:0] == CMD_COMMIT) begin
                    commit_stb = 1'b1;
                    state_d    = ST_IGNORE;
                end else begin
                    badcmd_stb = 1'b1;
                    state_d    = ST_IGNORE;
                end
            end
            ST_ADDR: if (bitcnt_q == CW'(7)) begin
                bitcnt_d = '0;
                ptr_d    = word[7:0];
                state_d  = ST_DATA;
            end
            ST_DATA: if (bitcnt_q == CW'(COEFF_W-1)) begin
                bitcnt_d = '0;
                wr_stb   = 1'b1;
                ptr_d    = ptr_q + 8'd1;
            end
            default: begin
                bitcnt_d = bitcnt_q;
                state_d  = ST_IGNORE;
            end
        endcase
    end

    always_ff @(posedge SCLK or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCOEFF; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            tgl_q      <= 1'b0;
            bad_addr_q <= 1'b0;
            bad_cmd_q  <= 1'b0;
        end else begin
            if (wr_stb) begin
                if (ptr_q < 8'(NCOEFF)) shadow_q[ptr_q[3:0]] <= word;
                else                    bad_addr_q           <= 1'b1;
            end
            if (commit_stb) begin
                active_q <= shadow_q;
                tgl_q    <= ~tgl_q;
            end
            if (badcmd_stb) bad_cmd_q <= 1'b1;
        end
    end

    assign hp_y1_coeff      = active_q[0];
    assign hp_y2_coeff      = active_q[1];
    assign hp_x0_coeff      = active_q[2];
    assign hp_x1_coeff      = active_q[3];
    assign hp_x2_coeff      = active_q[4];
    assign lp_y1_coeff      = active_q[5];
    assign lp_y2_coeff      = active_q[6];
    assign lp_x0_coeff      = active_q[7];
    assign lp_x1_coeff      = active_q[8];
    assign lp_x2_coeff      = active_q[9];
    assign coeff_update_tgl = tgl_q;
    assign bad_addr         = bad_addr_q;
    assign bad_cmd          = bad_cmd_q;
endmodule

// File: tb/tb_spi_coeff_loader.sv
// Directed bench for spi_coeff_loader: write/commit frames, burst overflow,
// partial words, bad opcodes and mid-frame reset.
module tb_spi_coeff_loader;
    logic SCLK = 1'b0, reset_n = 1'b0, CS = 1'b1, MOSI = 1'b0;
    logic [63:0] hp_y1, hp_y2, hp_x0, hp_x1, hp_x2, lp_y1, lp_y2, lp_x0, lp_x1, lp_x2;
    logic tgl, bad_addr, bad_cmd;

    int vectors = 0, miscompares = 0;
    logic [63:0] exp_act [10];
    logic        exp_tgl;
    logic [63:0] obs_act [10];

    localparam logic [63:0] V = 64'h0000_0001_0000_0000;
    localparam logic [63:0] D = 64'h8000_0000_0000_0005;
    localparam logic [63:0] A = 64'hDEAD_BEEF_0123_4567;
    localparam logic [63:0] B = 64'h0F0F_F0F0_5A5A_A5A5;
    localparam logic [63:0] C = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] F = 64'h1234_5678_9ABC_DEF0;

    spi_coeff_loader dut (
        .SCLK(SCLK), .reset_n(reset_n), .CS(CS), .MOSI(MOSI),
        .hp_y1_coeff(hp_y1), .hp_y2_coeff(hp_y2), .hp_x0_coeff(hp_x0),
        .hp_x1_coeff(hp_x1), .hp_x2_coeff(hp_x2),
        .lp_y1_coeff(lp_y1), .lp_y2_coeff(lp_y2), .lp_x0_coeff(lp_x0),
        .lp_x1_coeff(lp_x1), .lp_x2_coeff(lp_x2),
        .coeff_update_tgl(tgl), .bad_addr(bad_addr), .bad_cmd(bad_cmd)
    );

    always #5 SCLK = ~SCLK;

    always_comb begin
        obs_act[0] = hp_y1; obs_act[1] = hp_y2; obs_act[2] = hp_x0;
        obs_act[3] = hp_x1; obs_act[4] = hp_x2; obs_act[5] = lp_y1;
        obs_act[6] = lp_y2; obs_act[7] = lp_x0; obs_act[8] = lp_x1;
        obs_act[9] = lp_x2;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        for (int i = 0; i < 10; i++)
            chk($sformatf("%s.coeff%0d", tag, i), obs_act[i], exp_act[i]);
        chk({tag, ".tgl"}, {63'd0, tgl}, {63'd0, exp_tgl});
    endtask

    // MOSI changes just after posedge; the DUT samples on the next posedge.
    task automatic send(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            MOSI = v[i];
            @(posedge SCLK);
            #1;
        end
    endtask

    task automatic cs_low();
        @(negedge SCLK);
        CS = 1'b0;
    endtask

    task automatic cs_high();
        @(negedge SCLK);
        CS = 1'b1;
        @(negedge SCLK);
    endtask

    task automatic write_frame(input logic [7:0] addr, input logic [63:0] w);
        cs_low();
        send(64'h02, 8);
        send({56'd0, addr}, 8);
        send(w, 64);
        cs_high();
    endtask

    task automatic commit_frame();
        cs_low();
        send(64'h03, 8);
        cs_high();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 10; i++) exp_act[i] = '0;
        exp_tgl = 1'b0;
        #23 reset_n = 1'b1;
        @(negedge SCLK);

        chk_all("reset");
        chk("reset.bad_addr", {63'd0, bad_addr}, 64'd0);
        chk("reset.bad_cmd",  {63'd0, bad_cmd},  64'd0);

        // Shadow write must not reach outputs; commit lands on the 8th opcode edge.
        write_frame(8'h02, V);
        chk("w2.hp_x0_before_commit", hp_x0, 64'd0);
        cs_low();
        send(64'h01, 7);
        chk("commit7.hp_x0", hp_x0, 64'd0);
        chk("commit7.tgl", {63'd0, tgl}, 64'd0);
        send(64'h01, 1);
        exp_act[2] = V; exp_tgl = 1'b1;
        chk_all("commit8");
        cs_high();

        // Establish lp_y1, then a 40-bit partial word must leave it untouched.
        write_frame(8'h05, D);
        commit_frame();
        exp_act[5] = D; exp_tgl = 1'b0;
        chk_all("w5");
        cs_low();
        send(64'h02, 8);
        send(64'h05, 8);
        send(64'hAB_CDEF_0123, 40);
        cs_high();
        commit_frame();
        exp_tgl = 1'b1;
        chk_all("partial");
        chk("partial.bad_addr", {63'd0, bad_addr}, 64'd0);

        // Burst at 8: A->8, B->9, C hits address 10 and is dropped.
        cs_low();
        send(64'h02, 8);
        send(64'h08, 8);
        send(A, 64);
        send(B, 64);
        send(C, 64);
        cs_high();
        chk("burst.bad_addr", {63'd0, bad_addr}, 64'd1);
        chk_all("burst_precommit");
        commit_frame();
        exp_act[8] = A; exp_act[9] = B; exp_tgl = 1'b0;
        chk_all("burst_commit");

        // Unknown opcode followed by 80 bits changes nothing but bad_cmd.
        write_frame(8'h00, F);
        cs_low();
        send(64'hFF, 8);
        send(64'h0203_0000_0000_0002, 64);
        send(64'h0302, 16);
        cs_high();
        chk("badop.bad_cmd", {63'd0, bad_cmd}, 64'd1);
        chk_all("badop");
        commit_frame();
        exp_act[0] = F; exp_tgl = 1'b1;
        chk_all("after_badop");

        // Reset 70 edges into a write frame, then decode a fresh opcode with CS still low.
        cs_low();
        send(64'h02, 8);
        send(64'h00, 8);
        send(64'h3FFF_FFFF_FFFF_FFFF, 54);
        reset_n = 1'b0;
        #2;
        for (int i = 0; i < 10; i++) exp_act[i] = '0;
        exp_tgl = 1'b0;
        chk_all("midreset");
        chk("midreset.bad_addr", {63'd0, bad_addr}, 64'd0);
        chk("midreset.bad_cmd",  {63'd0, bad_cmd},  64'd0);
        reset_n = 1'b1;
        send(64'h03, 8);
        exp_tgl = 1'b1;
        chk_all("fresh_commit");
        chk("fresh_commit.bad_cmd", {63'd0, bad_cmd}, 64'd0);
        cs_high();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
